// File: rtl/difftest_pkg.sv
// Purpose : shared DiffTest verdict codes and checker entry points for the deferred-result endpoint.
// Latency : n/a (package).
// Backpressure: none; checker calls are void/non-blocking from the hardware side.
package difftest_pkg;

    localparam logic [7:0] SIMV_NONE     = 8'd0;
    localparam logic [7:0] SIMV_GOODTRAP = 8'd1;
    localparam logic [7:0] SIMV_EXCEED   = 8'd2;
    localparam logic [7:0] SIMV_FAIL     = 8'd3;
    localparam logic [7:0] SIMV_WARMUP   = 8'd4;

    // Checker-side state. The entry points below have the same signatures as
    // the C checker's simv_nstep / simv_result_fetch; this SV body keeps the
    // slice self-contained by logging step counts and replaying a verdict
    // queue. Every mutation is a queue method call so no plain variable is
    // assigned from several always_ff blocks.
    byte nstep_log[$];      // every n passed to simv_nstep, in call order
    int  verdict_script[$]; // verdict returned by the k-th fetch (0 past the end)
    bit  fetch_log[$];      // one entry per simv_result_fetch call

    function automatic void simv_nstep(input byte n);
        nstep_log.push_back(n);
    endfunction

    // Returns the latest verdict and consumes it, so a later fetch sees the
    // next scripted entry (or 0 when nothing new is pending).
    function automatic int simv_result_fetch();
        int idx;
        idx = fetch_log.size();
        fetch_log.push_back(1'b1);
        return (idx < verdict_script.size()) ? verdict_script[idx] : 0;
    endfunction

    // Only codes 1..4 are meaningful; anything else collapses to SIMV_NONE.
    function automatic logic [7:0] simv_code_filter(input int raw);
        logic [7:0] code;
        code = SIMV_NONE;
        if (raw >= int'(SIMV_GOODTRAP) && raw <= int'(SIMV_WARMUP)) begin
            code = raw[7:0];
        end
        return code;
    endfunction

endpackage

// File: rtl/deferred_result_ctrl_timer.sv
// Purpose : period counter for verdict polling; fetch_now_o is high during the cycle whose closing edge polls.
// Latency : strobe on edge FETCH_PERIOD after reset release, then every FETCH_PERIOD edges.
// Backpressure: none; free-running while reset is low.
// Ports   : clock_i, reset_i (async, active high), fetch_now_o (one-cycle poll strobe).
module deferred_fetch_timer #(
    parameter int unsigned FETCH_PERIOD = 5000
) (
    input  logic clock_i,
    input  logic reset_i,
    output logic fetch_now_o
);

    localparam logic [31:0] LAST_COUNT = 32'(FETCH_PERIOD - 1);

    logic [31:0] timer_q;
    logic [31:0] timer_d;

    // The counter wraps at LAST_COUNT, so it never reaches the 32-bit limit.
    assign fetch_now_o = (timer_q == LAST_COUNT);
    assign timer_d     = fetch_now_o ? 32'd0 : timer_q + 32'd1;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            timer_q <= 32'd0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/deferred_result_ctrl.sv
// Purpose : forwards per-cycle commit step counts to the checker and polls its verdict every FETCH_PERIOD cycles.
// Latency : verdict appears on simv_result the cycle after the polling edge, for exactly one cycle.
// Backpressure: none; step calls are void and never wait on the checker.
// Ports   : clock, reset (async, active high), step (commits this cycle), simv_result (0 none, 1..4 verdict).
module deferred_result_ctrl
    import difftest_pkg::*;
#(
    parameter int unsigned STEP_WIDTH    = 8,
    parameter int unsigned FETCH_PERIOD  = 5000,
    parameter bit          INTERNAL_STEP = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [STEP_WIDTH-1:0] step,
    output logic [7:0]            simv_result
);

    logic       fetch_now;
    logic [7:0] step_byte;
    logic [7:0] simv_result_q;

    assign step_byte   = 8'(step);
    assign simv_result = simv_result_q;

    deferred_fetch_timer #(
        .FETCH_PERIOD(FETCH_PERIOD)
    ) u_fetch_timer (
        .clock_i    (clock),
        .reset_i    (reset),
        .fetch_now_o(fetch_now)
    );

    // Both calls live in one block so that on a shared edge the step is
    // handed over before the poll, and the fetched verdict already covers it.
    // The reset branch makes no calls, so the checker sees nothing in reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            simv_result_q <= SIMV_NONE;
        end else begin
            if (INTERNAL_STEP == 1'b0 && step != '0) begin
                simv_nstep(step_byte);
            end
            if (fetch_now) begin
                simv_result_q <= simv_code_filter(simv_result_fetch());
            end else begin
                simv_result_q <= SIMV_NONE;
            end
        end
    end

endmodule

// File: tb/tb_deferred_result_ctrl.sv
module tb_deferred_result_ctrl;
    import difftest_pkg::*;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic [7:0] step;
    logic [7:0] res_a, res_b, res_c;

    always #5 clk = ~clk;

    // a: period 8, forwarding; b: period 1, forwarding; c: period 8, internal step.
    // Only one instance is ever out of reset, so the shared checker sees one DUT.
    deferred_result_ctrl #(.STEP_WIDTH(8), .FETCH_PERIOD(8), .INTERNAL_STEP(1'b0)) dut_a (
        .clock(clk), .reset(rst_a), .step(step), .simv_result(res_a));
    deferred_result_ctrl #(.STEP_WIDTH(8), .FETCH_PERIOD(1), .INTERNAL_STEP(1'b0)) dut_b (
        .clock(clk), .reset(rst_b), .step(step), .simv_result(res_b));
    deferred_result_ctrl #(.STEP_WIDTH(8), .FETCH_PERIOD(8), .INTERNAL_STEP(1'b1)) dut_c (
        .clock(clk), .reset(rst_c), .step(step), .simv_result(res_c));

    int errors = 0;
    int checks = 0;
    int sel;
    int period;
    bit internal;
    int edge_n;
    int fetch_base;
    int log_base;
    int exp_log[$];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cur_result();
        case (sel)
            0:       return int'(res_a);
            1:       return int'(res_b);
            default: return int'(res_c);
        endcase
    endfunction

    function automatic int script_at(input int idx);
        return (idx < verdict_script.size()) ? verdict_script[idx] : 0;
    endfunction

    // Verdict presented on simv_result for a raw checker value.
    function automatic int expect_code(input int raw);
        return (raw >= 1 && raw <= 4) ? raw : 0;
    endfunction

    task automatic pad_script();
        while (verdict_script.size() < fetch_log.size()) verdict_script.push_back(0);
    endtask

    task automatic start_model();
        pad_script();
        fetch_base = fetch_log.size();
        log_base   = nstep_log.size();
        exp_log.delete();
        edge_n     = 0;
    endtask

    task automatic activate(input int s);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        step  = 8'd0;
        @(posedge clk); #1;
        sel      = s;
        period   = (s == 1) ? 1 : 8;
        internal = (s == 2);
        start_model();
        case (s)
            0:       rst_a = 1'b0;
            1:       rst_b = 1'b0;
            default: rst_c = 1'b0;
        endcase
    endtask

    // One edge: every edge_n that is a multiple of the period polls once and
    // shows the filtered scripted verdict for one cycle; otherwise 0.
    task automatic cycle(input int stp);
        int exp;
        step = stp[7:0];
        if (stp != 0 && !internal) exp_log.push_back(stp);
        @(posedge clk); #1;
        edge_n++;
        exp = 0;
        if (edge_n % period == 0) exp = expect_code(script_at(fetch_base + edge_n / period - 1));
        check($sformatf("result sel%0d edge%0d", sel, edge_n), cur_result(), exp);
        check($sformatf("fetches sel%0d edge%0d", sel, edge_n), fetch_log.size() - fetch_base, edge_n / period);
    endtask

    task automatic check_log(input string tag);
        int n;
        n = nstep_log.size() - log_base;
        check({tag, " nstep count"}, n, exp_log.size());
        for (int i = 0; i < n && i < exp_log.size(); i++) begin
            check($sformatf("%s nstep[%0d]", tag, i), int'(nstep_log[log_base + i]), exp_log[i]);
        end
    endtask

    initial begin
        int f_at;
        int l_at;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        step  = 8'd5;

        // Reset state, and no checker traffic across edges while in reset.
        #2;
        check("reset res_a", int'(res_a), 0);
        check("reset res_b", int'(res_b), 0);
        check("reset res_c", int'(res_c), 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset no fetch", fetch_log.size(), 0);
        check("reset no nstep", nstep_log.size(), 0);

        // Idle steps, period 8: polls at edges 8 and 16 only, no nstep calls.
        activate(0);
        repeat (20) cycle(0);
        check("idle fetch total", fetch_log.size() - fetch_base, 2);
        check_log("idle");

        // Step sequence 1,0,3,2 with forwarding, then with internal step.
        activate(0);
        cycle(1); cycle(0); cycle(3); cycle(2);
        repeat (4) cycle(0);
        check_log("seq fwd");
        activate(2);
        cycle(1); cycle(0); cycle(3); cycle(2);
        repeat (4) cycle(0);
        check_log("seq internal");

        // Verdict 3 on the second poll: one cycle after edge 16 only.
        activate(0);
        verdict_script.push_back(0);
        verdict_script.push_back(3);
        repeat (20) cycle(0);

        // Period 1: 4 then 1 on consecutive cycles, then back to 0.
        activate(1);
        verdict_script.push_back(4);
        verdict_script.push_back(1);
        repeat (3) cycle(0);

        // Out-of-range verdicts are discarded.
        activate(0);
        verdict_script.push_back(9);
        verdict_script.push_back(5);
        repeat (16) cycle(0);

        // Async reset at cycle 5 of 8, held across edges with step nonzero.
        activate(0);
        repeat (5) cycle(2);
        check_log("pre-reset");
        #3;
        rst_a = 1'b1;
        #1;
        check("async reset res", int'(res_a), 0);
        f_at = fetch_log.size();
        l_at = nstep_log.size();
        repeat (10) begin
            step = 8'd7;
            @(posedge clk); #1;
            check("held reset res", int'(res_a), 0);
            check("held reset fetch", fetch_log.size(), f_at);
            check("held reset nstep", nstep_log.size(), l_at);
        end
        step  = 8'd0;
        rst_a = 1'b0;
        start_model();
        verdict_script.push_back(2);
        repeat (8) cycle(0);

        // Reset during the verdict cycle clears the output without an edge.
        activate(0);
        verdict_script.push_back(3);
        repeat (8) cycle(0);
        #2;
        rst_a = 1'b1;
        #1;
        check("reset clears verdict", int'(res_a), 0);

        // Random steps and verdicts, period 8.
        activate(0);
        repeat (10) verdict_script.push_back(int'($urandom_range(0, 9)));
        repeat (80) cycle(($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 100)));
        check_log("rand p8");

        // Random steps and verdicts, period 1.
        activate(1);
        repeat (20) verdict_script.push_back(int'($urandom_range(0, 9)));
        repeat (20) cycle(($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 100)));
        check_log("rand p1");

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
